// File: rtl/mem_req_arbiter.sv
// Memory request arbiter: N requesters share one memory port, responses are routed back in order via an ID FIFO.
// Define MEM_REQ_ARBITER_RR_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).
module mem_req_arbiter #(
  parameter int unsigned NumReq    = 2,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned MaxTrans  = 4,
  parameter int unsigned StrbWidth = DataWidth / 8,
  parameter int unsigned IdxWidth  = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [NumReq-1:0]                  req_i,
  output logic [NumReq-1:0]                  gnt_o,
  input  logic [NumReq-1:0][AddrWidth-1:0]   addr_i,
  input  logic [NumReq-1:0]                  we_i,
  input  logic [NumReq-1:0][DataWidth-1:0]   wdata_i,
  input  logic [NumReq-1:0][StrbWidth-1:0]   strb_i,
  output logic [NumReq-1:0]                  rvalid_o,
  output logic [NumReq-1:0][DataWidth-1:0]   rdata_o,
  output logic                               req_o,
  input  logic                               gnt_i,
  output logic [AddrWidth-1:0]               addr_o,
  output logic                               we_o,
  output logic [DataWidth-1:0]               wdata_o,
  output logic [StrbWidth-1:0]               strb_o,
  input  logic                               rvalid_i,
  input  logic [DataWidth-1:0]               rdata_i
);

  localparam int unsigned PtrWidth = (MaxTrans > 1) ? $clog2(MaxTrans) : 1;
  localparam int unsigned CntWidth = $clog2(MaxTrans + 1);
  localparam logic [CntWidth-1:0] CntFull = CntWidth'(MaxTrans);
  localparam logic [PtrWidth-1:0] PtrLast = PtrWidth'(MaxTrans - 1);
  localparam logic [NumReq-1:0]   OneHot0 = NumReq'(1);

  logic [CntWidth-1:0] r_count;
  logic [PtrWidth-1:0] r_wptr;
  logic [PtrWidth-1:0] r_rptr;
  logic [IdxWidth-1:0] r_fifo [MaxTrans];
  logic                r_locked;
  logic [IdxWidth-1:0] r_lock_idx;

  logic [IdxWidth-1:0] w_arb_idx;
  logic [IdxWidth-1:0] w_win_idx;
  logic                w_lock_hold;
  logic                w_full;
  logic                w_hs;
  logic                w_pop;

`ifdef MEM_REQ_ARBITER_RR_EN
  logic [IdxWidth-1:0] r_rr_ptr;

  function automatic logic [IdxWidth-1:0] pick_rr(input logic [NumReq-1:0] req,
                                                  input logic [IdxWidth-1:0] ptr);
    logic found;
    int   j;
    pick_rr = ptr;
    found   = 1'b0;
    for (int i = 0; i < int'(NumReq); i++) begin
      j = int'(ptr) + i;
      if (j >= int'(NumReq)) j = j - int'(NumReq);
      if (!found && req[j]) begin
        found   = 1'b1;
        pick_rr = IdxWidth'(j);
      end
    end
  endfunction

  assign w_arb_idx = pick_rr(req_i, r_rr_ptr);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rr_ptr <= '0;
    end else if (w_hs) begin
      r_rr_ptr <= (int'(w_win_idx) == int'(NumReq) - 1) ? '0 : w_win_idx + 1'b1;
    end
  end
`else
  function automatic logic [IdxWidth-1:0] pick_fixed(input logic [NumReq-1:0] req);
    pick_fixed = '0;
    for (int i = int'(NumReq) - 1; i >= 0; i--) begin
      if (req[i]) pick_fixed = IdxWidth'(i);
    end
  endfunction

  assign w_arb_idx = pick_fixed(req_i);
`endif

  // A registered winner stays in charge only while it keeps requesting.
  assign w_lock_hold = r_locked && req_i[r_lock_idx];
  assign w_win_idx   = w_lock_hold ? r_lock_idx : w_arb_idx;

  assign w_full = (r_count == CntFull);
  assign req_o  = (|req_i) && !w_full;
  assign w_hs   = req_o && gnt_i;
  assign w_pop  = rvalid_i && (r_count != '0);

  assign gnt_o   = w_hs ? (OneHot0 << w_win_idx) : '0;
  assign addr_o  = addr_i[w_win_idx];
  assign we_o    = we_i[w_win_idx];
  assign wdata_o = wdata_i[w_win_idx];
  assign strb_o  = strb_i[w_win_idx];

  assign rvalid_o = w_pop ? (OneHot0 << r_fifo[r_rptr]) : '0;
  assign rdata_o  = {NumReq{rdata_i}};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_locked   <= 1'b0;
      r_lock_idx <= '0;
    end else begin
      r_locked   <= req_o && !gnt_i;
      r_lock_idx <= w_win_idx;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_count <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
    end else begin
      if (w_hs) r_wptr <= (r_wptr == PtrLast) ? '0 : r_wptr + 1'b1;
      if (w_pop) r_rptr <= (r_rptr == PtrLast) ? '0 : r_rptr + 1'b1;
      case ({w_hs, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read once counted in.
  always_ff @(posedge clk_i) begin
    if (w_hs) r_fifo[r_wptr] <= w_win_idx;
  end

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    if (rst_ni) begin
      assert (!(rvalid_i && (r_count == '0)))
        else $warning("mem_req_arbiter: rvalid_i with no outstanding transaction dropped");
    end
  end
`endif

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter (NumReq=2, MaxTrans=2); expectations follow MEM_REQ_ARBITER_RR_EN.
module tb_mem_req_arbiter;

  localparam int NR = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic                   clk_i = 1'b0;
  logic                   rst_ni;
  logic [NR-1:0]          req_i;
  logic [NR-1:0]          gnt_o;
  logic [NR-1:0][AW-1:0]  addr_i;
  logic [NR-1:0]          we_i;
  logic [NR-1:0][DW-1:0]  wdata_i;
  logic [NR-1:0][SW-1:0]  strb_i;
  logic [NR-1:0]          rvalid_o;
  logic [NR-1:0][DW-1:0]  rdata_o;
  logic                   req_o;
  logic                   gnt_i;
  logic [AW-1:0]          addr_o;
  logic                   we_o;
  logic [DW-1:0]          wdata_o;
  logic [SW-1:0]          strb_o;
  logic                   rvalid_i;
  logic [DW-1:0]          rdata_i;

  int checks = 0;
  int failures = 0;

  mem_req_arbiter #(.NumReq(NR), .AddrWidth(AW), .DataWidth(DW), .MaxTrans(2)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_i(req_i), .gnt_o(gnt_o), .addr_i(addr_i), .we_i(we_i),
    .wdata_i(wdata_i), .strb_i(strb_i), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .req_o(req_o), .gnt_i(gnt_i), .addr_o(addr_o), .we_o(we_o),
    .wdata_o(wdata_o), .strb_o(strb_o), .rvalid_i(rvalid_i), .rdata_i(rdata_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  // Advance one clock; inputs are then changed 1 time unit after the edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic [1:0] req, input logic gnt, input logic rv, input logic [DW-1:0] rd);
    req_i = req; gnt_i = gnt; rvalid_i = rv; rdata_i = rd;
    #1;
  endtask

  initial begin
    logic [1:0] exp_g;
    logic [1:0] exp_r;
    rst_ni = 1'b0;
    req_i = '0; gnt_i = 1'b0; rvalid_i = 1'b0; rdata_i = '0;
    addr_i[0] = 32'h100; addr_i[1] = 32'h200;
    we_i = 2'b10;
    wdata_i[0] = 32'hD0; wdata_i[1] = 32'hD1;
    strb_i[0] = 4'hF; strb_i[1] = 4'h3;
    #2;
    chk("rst_req_o", 64'(req_o), 64'd0);
    chk("rst_gnt_o", 64'(gnt_o), 64'd0);
    chk("rst_rvalid_o", 64'(rvalid_o), 64'd0);
    step();
    rst_ni = 1'b1;
    step();

    // Idle plus a stray response on an empty FIFO
    drive(2'b00, 1'b0, 1'b1, 32'h77);
    chk("idle_req_o", 64'(req_o), 64'd0);
    chk("empty_drop_rvalid", 64'(rvalid_o), 64'd0);
    step();

    // a: both request, memory grants
    drive(2'b11, 1'b1, 1'b0, 32'h0);
    chk("a_gnt", 64'(gnt_o), 64'b01);
    chk("a_addr", 64'(addr_o), 64'h100);
    chk("a_we", 64'(we_o), 64'd0);
    step();
    // b: handshake + pop together, count stays 1
`ifdef MEM_REQ_ARBITER_RR_EN
    exp_g = 2'b10;
`else
    exp_g = 2'b01;
`endif
    drive(2'b11, 1'b1, 1'b1, 32'h11);
    chk("b_gnt", 64'(gnt_o), 64'(exp_g));
    chk("b_rvalid", 64'(rvalid_o), 64'b01);
    chk("b_rdata0", 64'(rdata_o[0]), 64'h11);
    step();
    // c
`ifdef MEM_REQ_ARBITER_RR_EN
    exp_g = 2'b01; exp_r = 2'b10;
`else
    exp_g = 2'b01; exp_r = 2'b01;
`endif
    drive(2'b11, 1'b1, 1'b1, 32'h22);
    chk("c_gnt", 64'(gnt_o), 64'(exp_g));
    chk("c_rvalid", 64'(rvalid_o), 64'(exp_r));
    step();
    // d: push only -> count 2 (full)
`ifdef MEM_REQ_ARBITER_RR_EN
    exp_g = 2'b10;
`else
    exp_g = 2'b01;
`endif
    drive(2'b11, 1'b1, 1'b0, 32'h0);
    chk("d_gnt", 64'(gnt_o), 64'(exp_g));
    step();
    // e: full, pop in same cycle still blocks request
    drive(2'b11, 1'b1, 1'b1, 32'h33);
    chk("e_full_req_o", 64'(req_o), 64'd0);
    chk("e_full_gnt", 64'(gnt_o), 64'd0);
    chk("e_rvalid", 64'(rvalid_o), 64'b01);
    step();
    // f: one slot free -> req_o back up
`ifdef MEM_REQ_ARBITER_RR_EN
    exp_r = 2'b10;
`else
    exp_r = 2'b01;
`endif
    drive(2'b11, 1'b0, 1'b1, 32'h44);
    chk("f_req_o", 64'(req_o), 64'd1);
    chk("f_gnt", 64'(gnt_o), 64'd0);
    chk("f_rvalid", 64'(rvalid_o), 64'(exp_r));
    chk("f_rdata1", 64'(rdata_o[1]), 64'h44);
    step();
    drive(2'b00, 1'b0, 1'b0, 32'h0);
    chk("g_req_o", 64'(req_o), 64'd0);
    step();

    // Winner lock: requester 1 stalls, requester 0 arrives later
    drive(2'b10, 1'b0, 1'b0, 32'h0);
    chk("h1_req_o", 64'(req_o), 64'd1);
    chk("h1_addr", 64'(addr_o), 64'h200);
    step();
    drive(2'b10, 1'b0, 1'b0, 32'h0);
    chk("h2_addr", 64'(addr_o), 64'h200);
    step();
    drive(2'b11, 1'b0, 1'b0, 32'h0);
    chk("h3_addr_locked", 64'(addr_o), 64'h200);
    chk("h3_we", 64'(we_o), 64'd1);
    chk("h3_wdata", 64'(wdata_o), 64'hD1);
    chk("h3_strb", 64'(strb_o), 64'h3);
    step();
    drive(2'b11, 1'b1, 1'b0, 32'h0);
    chk("h4_gnt_locked", 64'(gnt_o), 64'b10);
    chk("h4_addr", 64'(addr_o), 64'h200);
    step();
    drive(2'b11, 1'b0, 1'b0, 32'h0);
    chk("h5_rearb_addr", 64'(addr_o), 64'h100);
    step();
    drive(2'b10, 1'b0, 1'b0, 32'h0);
    chk("h6_drop_addr", 64'(addr_o), 64'h200);
    step();

    // In-order routing 1,0,1 (entry for 1 already queued from h4)
    drive(2'b01, 1'b1, 1'b0, 32'h0);
    chk("i1_gnt", 64'(gnt_o), 64'b01);
    step();
    drive(2'b00, 1'b0, 1'b1, 32'hA);
    chk("i2_rvalid", 64'(rvalid_o), 64'b10);
    chk("i2_rdata1", 64'(rdata_o[1]), 64'hA);
    step();
    drive(2'b10, 1'b1, 1'b1, 32'hB);
    chk("i3_gnt", 64'(gnt_o), 64'b10);
    chk("i3_rvalid", 64'(rvalid_o), 64'b01);
    chk("i3_rdata0", 64'(rdata_o[0]), 64'hB);
    step();
    drive(2'b00, 1'b0, 1'b1, 32'hC);
    chk("i4_rvalid", 64'(rvalid_o), 64'b10);
    chk("i4_rdata1", 64'(rdata_o[1]), 64'hC);
    step();

    // Fill, then reset with two outstanding
    drive(2'b11, 1'b1, 1'b0, 32'h0);
    chk("j1_req_o", 64'(req_o), 64'd1);
    step();
    drive(2'b11, 1'b1, 1'b0, 32'h0);
    chk("j2_req_o", 64'(req_o), 64'd1);
    step();
    drive(2'b11, 1'b0, 1'b0, 32'h0);
    chk("j3_full_req_o", 64'(req_o), 64'd0);
    drive(2'b00, 1'b0, 1'b0, 32'h0);
    rst_ni = 1'b0;
    #1;
    chk("k_rst_req_o", 64'(req_o), 64'd0);
    chk("k_rst_gnt", 64'(gnt_o), 64'd0);
    chk("k_rst_rvalid", 64'(rvalid_o), 64'd0);
    step();
    rst_ni = 1'b1;
    step();
    drive(2'b01, 1'b1, 1'b0, 32'h0);
    chk("k1_gnt", 64'(gnt_o), 64'b01);
    step();
    drive(2'b00, 1'b0, 1'b1, 32'h5A);
    chk("k2_rvalid", 64'(rvalid_o), 64'b01);
    chk("k2_rdata0", 64'(rdata_o[0]), 64'h5A);
    step();
    drive(2'b00, 1'b0, 1'b1, 32'h5B);
    chk("k3_empty_rvalid", 64'(rvalid_o), 64'd0);
    step();
    drive(2'b00, 1'b0, 1'b0, 32'h0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
